// File: rtl/s_axis_stream_router_pkg.sv
// Shared constants for the stream router: mode encodings, FSM state encodings,
// header select width and the default per-channel payload width.
package s_axis_stream_router_pkg;

    localparam logic MODE_BEAT   = 1'b0;
    localparam logic MODE_PACKET = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_FWD  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    localparam int HDR_SEL_W          = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Width of a register able to hold a channel index 0..n-1 (at least one bit).
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/s_axis_stream_router_if.sv
// Bundles the slave AXI4-Stream input and the NUM_CH buffered master channels.
// slave = router side, master = the environment driving the stream and the channel readies.
interface s_axis_stream_router_if #(
    parameter int TDATA_W    = 32,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2
) ();
    logic [TDATA_W-1:0]           s_tdata;
    logic [TDATA_W/8-1:0]         s_tstrb;
    logic                         s_tlast;
    logic                         s_tvalid;
    logic                         s_tready;

    logic [NUM_CH*DATA_WIDTH-1:0] m_data;
    logic [NUM_CH-1:0]            m_valid;
    logic [NUM_CH-1:0]            m_last;
    logic [NUM_CH-1:0]            m_ready;

    modport slave (
        input  s_tdata, s_tstrb, s_tlast, s_tvalid,
        output s_tready,
        output m_data, m_valid, m_last,
        input  m_ready
    );

    modport master (
        output s_tdata, s_tstrb, s_tlast, s_tvalid,
        input  s_tready,
        input  m_data, m_valid, m_last,
        output m_ready
    );
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer with a registered head; the head drives the channel output
// directly, so an accepted push is visible one cycle later.
module axis_skid_buf #(
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_space,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_head_valid;
    logic             r_tail_valid;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_pop;

    assign w_pop   = r_head_valid && i_ready;
    assign o_space = !r_tail_valid || w_pop;
    assign o_valid = r_head_valid;
    assign o_data  = r_head;

    // NOTE: r_tail is storage only and is never observed while r_tail_valid is low,
    // so it is left out of reset; the visible head is cleared so outputs read zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head_valid <= 1'b0;
            r_tail_valid <= 1'b0;
            r_head       <= '0;
        end else if (w_pop) begin
            if (r_tail_valid) begin
                r_head       <= r_tail;
                r_tail_valid <= i_push;
                if (i_push) r_tail <= i_data;
            end else begin
                r_head_valid <= i_push;
                if (i_push) r_head <= i_data;
            end
        end else if (i_push) begin
            if (!r_head_valid) begin
                r_head       <= i_data;
                r_head_valid <= 1'b1;
            end else begin
                r_tail       <= i_data;
                r_tail_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/s_axis_stream_router.sv
// Splits one AXI4-Stream into NUM_CH skid-buffered channels, either per beat by a lane
// mask (BEAT) or per packet by a header beat selecting the channel (PACKET).
module s_axis_stream_router
    import s_axis_stream_router_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int DATA_WIDTH           = DEFAULT_DATA_WIDTH,
    parameter int NUM_CH               = 2,
    parameter int MASK_LSB             = 16,
    parameter int CNT_W                = 16
) (
    input  logic                          i_s_axis_aclk,
    input  logic                          i_s_axis_areset,
    input  logic                          i_cfg_mode,
    s_axis_stream_router_if.slave         bus,
    output logic [CNT_W-1:0]              o_drop_count,
    output logic                          o_busy
);
    localparam int                    SEL_W      = sel_width(NUM_CH);
    localparam logic [HDR_SEL_W-1:0]  NUM_CH_SEL = HDR_SEL_W'(NUM_CH);

    logic                            r_mode;
    logic [1:0]                      r_state;
    logic [SEL_W-1:0]                r_sel;
    logic [CNT_W-1:0]                r_drop_count;

    logic [C_S_AXIS_TDATA_WIDTH-1:0] w_tdata;
    logic [NUM_CH-1:0]               w_mask;
    logic [HDR_SEL_W-1:0]            w_hdr_sel;
    logic                            w_hdr_valid;
    logic                            w_tready;
    logic                            w_accept;
    logic                            w_drop_inc;
    logic [NUM_CH-1:0]               w_space;
    logic [NUM_CH-1:0]               w_push;
    logic [NUM_CH-1:0]               w_ch_valid;
    logic [DATA_WIDTH-1:0]           w_push_data [NUM_CH];
    logic [DATA_WIDTH:0]             w_ch_word   [NUM_CH];

    assign w_tdata     = bus.s_tdata;
    assign w_mask      = w_tdata[MASK_LSB +: NUM_CH];
    assign w_hdr_sel   = w_tdata[HDR_SEL_W-1:0];
    assign w_hdr_valid = w_hdr_sel < NUM_CH_SEL;
    assign w_accept    = bus.s_tvalid && w_tready;
    assign bus.s_tready = w_tready;
    assign o_drop_count = r_drop_count;
    assign o_busy       = (r_state != ST_IDLE);

    // tready is derived from buffer space and FSM state only, never from tvalid.
    always_comb begin
        w_tready = 1'b0;
        if (!i_s_axis_areset) begin
            if (r_mode == MODE_BEAT) begin
                w_tready = &(w_space | ~w_mask);
            end else if (r_state == ST_FWD) begin
                w_tready = w_space[r_sel];
            end else begin
                w_tready = 1'b1;
            end
        end
    end

    always_comb begin
        w_push     = '0;
        w_drop_inc = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_push_data[c] = (r_mode == MODE_BEAT) ? w_tdata[c*DATA_WIDTH +: DATA_WIDTH]
                                                   : w_tdata[DATA_WIDTH-1:0];
        end
        if (w_accept) begin
            if (r_mode == MODE_BEAT) begin
                w_push     = w_mask;
                w_drop_inc = (w_mask == '0);
            end else begin
                case (r_state)
                    ST_IDLE, ST_HDR: w_drop_inc    = !w_hdr_valid;
                    ST_FWD:          w_push[r_sel] = 1'b1;
                    default:         w_drop_inc    = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge i_s_axis_aclk) begin
        if (i_s_axis_areset) begin
            r_mode       <= MODE_BEAT;
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_drop_count <= '0;
        end else begin
            if (r_state == ST_IDLE && !w_accept) r_mode <= i_cfg_mode;
            if (w_drop_inc && r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
            if (w_accept && r_mode == MODE_PACKET) begin
                case (r_state)
                    ST_IDLE, ST_HDR: begin
                        // A header carrying tlast is an empty packet: nothing follows it.
                        if (bus.s_tlast) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= w_hdr_valid ? ST_FWD : ST_DROP;
                            r_sel   <= w_hdr_sel[SEL_W-1:0];
                        end
                    end
                    default: if (bus.s_tlast) r_state <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        axis_skid_buf #(
            .WIDTH (DATA_WIDTH + 1)
        ) u_buf (
            .i_clk   (i_s_axis_aclk),
            .i_rst   (i_s_axis_areset),
            .i_push  (w_push[c]),
            .i_data  ({bus.s_tlast, w_push_data[c]}),
            .i_ready (bus.m_ready[c]),
            .o_space (w_space[c]),
            .o_valid (w_ch_valid[c]),
            .o_data  (w_ch_word[c])
        );
    end

    always_comb begin
        bus.m_data  = '0;
        bus.m_last  = '0;
        bus.m_valid = w_ch_valid;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.m_data[c*DATA_WIDTH +: DATA_WIDTH] = w_ch_word[c][DATA_WIDTH-1:0];
            bus.m_last[c]                          = w_ch_word[c][DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_s_axis_stream_router.sv
// Self-checking bench for s_axis_stream_router: directed scenarios plus random traffic
// in both modes, checked against a behavioural scoreboard of per-channel queues.
module tb_s_axis_stream_router;
    import s_axis_stream_router_pkg::*;

    localparam int TDW = 32;
    localparam int DW  = 8;
    localparam int NCH = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_mode;
    logic [15:0] drop_count;
    logic        busy;
    logic [3:0]  drop_count2;
    logic        busy2;

    always #5 clk = ~clk;

    s_axis_stream_router_if #(.TDATA_W(TDW), .DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();
    s_axis_stream_router_if #(.TDATA_W(TDW), .DATA_WIDTH(DW), .NUM_CH(NCH)) bus2 ();

    s_axis_stream_router #(
        .C_S_AXIS_TDATA_WIDTH (TDW), .DATA_WIDTH (DW), .NUM_CH (NCH), .MASK_LSB (16), .CNT_W (16)
    ) u_dut (
        .i_s_axis_aclk (clk), .i_s_axis_areset (rst), .i_cfg_mode (cfg_mode),
        .bus (bus), .o_drop_count (drop_count), .o_busy (busy)
    );

    s_axis_stream_router #(
        .C_S_AXIS_TDATA_WIDTH (TDW), .DATA_WIDTH (DW), .NUM_CH (NCH), .MASK_LSB (16), .CNT_W (4)
    ) u_dut_sat (
        .i_s_axis_aclk (clk), .i_s_axis_areset (rst), .i_cfg_mode (1'b0),
        .bus (bus2), .o_drop_count (drop_count2), .o_busy (busy2)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pop [NCH];
    exp_t        exp_q [NCH][$];
    exp_t        e;
    logic [15:0] exp_drop;
    int          m_state;   // 0 = waiting for header, 1 = forwarding, 2 = dropping
    int          m_sel;

    task automatic bump_drop();
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    endtask

    // Reference behaviour for one accepted input beat.
    task automatic model_accept(input logic [31:0] d, input logic l);
        logic [1:0] mask;
        exp_t       x;
        if (cfg_mode == MODE_BEAT) begin
            mask = d[17:16];
            if (mask == 2'b00) bump_drop();
            for (int c = 0; c < NCH; c++) begin
                if (mask[c]) begin
                    x.data = d[c*DW +: DW];
                    x.last = l;
                    exp_q[c].push_back(x);
                end
            end
        end else begin
            case (m_state)
                0: begin
                    m_sel = int'(d[7:0]);
                    if (m_sel >= NCH) bump_drop();
                    if (!l) m_state = (m_sel < NCH) ? 1 : 2;
                end
                1: begin
                    x.data = d[DW-1:0];
                    x.last = l;
                    exp_q[m_sel].push_back(x);
                    if (l) m_state = 0;
                end
                default: begin
                    bump_drop();
                    if (l) m_state = 0;
                end
            endcase
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on every channel handshake.
    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) exp_q[c].delete();
            m_state  = 0;
            exp_drop = 16'd0;
        end else begin
            if (bus.s_tvalid && bus.s_tready) model_accept(bus.s_tdata, bus.s_tlast);
            for (int c = 0; c < NCH; c++) begin
                if (bus.m_valid[c] && bus.m_ready[c]) begin
                    n_pop[c]++;
                    n_cmp++;
                    if (exp_q[c].size() == 0) begin
                        n_err++;
                        $display("FAIL sb_ch%0d: got data=%h last=%b, expected no beat",
                                 c, bus.m_data[c*DW +: DW], bus.m_last[c]);
                    end else begin
                        e = exp_q[c].pop_front();
                        if ({bus.m_data[c*DW +: DW], bus.m_last[c]} !== {e.data, e.last}) begin
                            n_err++;
                            $display("FAIL sb_ch%0d: got data=%h last=%b, expected data=%h last=%b",
                                     c, bus.m_data[c*DW +: DW], bus.m_last[c], e.data, e.last);
                        end
                    end
                end
            end
        end
    end

    // Drives one beat from posedge+1 and returns at posedge+1 after it was accepted.
    task automatic send_beat(input logic [31:0] d, input logic l);
        bit ok = 1'b0;
        bus.s_tdata  = d;
        bus.s_tlast  = l;
        bus.s_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: beat %h not accepted within 200 cycles", d);
        end
        @(posedge clk);
        #1;
        bus.s_tvalid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic m);
        bus.s_tvalid = 1'b0;
        cfg_mode     = m;
        wait_cycles(3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        n_cmp++; if (bus.s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b expected 0", bus.s_tready); end
        n_cmp++; if (bus.m_valid !== 2'b00) begin n_err++; $display("FAIL reset_m_valid: got %b expected 00", bus.m_valid); end
        n_cmp++; if (bus.m_last !== 2'b00) begin n_err++; $display("FAIL reset_m_last: got %b expected 00", bus.m_last); end
        n_cmp++; if (bus.m_data !== 16'h0000) begin n_err++; $display("FAIL reset_m_data: got %h expected 0000", bus.m_data); end
        n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        wait_cycles(1);
    endtask

    task automatic test_beat_basic();
        set_mode(MODE_BEAT);
        bus.m_ready = 2'b11;
        send_beat(32'h0003_A55A, 1'b1);
        n_cmp++; if (bus.m_valid !== 2'b11) begin n_err++; $display("FAIL beat_valid: got %b expected 11", bus.m_valid); end
        n_cmp++; if (bus.m_data !== 16'hA55A) begin n_err++; $display("FAIL beat_data: got %h expected a55a", bus.m_data); end
        n_cmp++; if (bus.m_last !== 2'b11) begin n_err++; $display("FAIL beat_last: got %b expected 11", bus.m_last); end
        wait_cycles(2);
    endtask

    task automatic test_backpressure();
        logic [15:0] d0;
        bit          ok = 1'b0;
        bus.m_ready = 2'b01;
        send_beat(32'h0003_1101, 1'b0);
        send_beat(32'h0003_2202, 1'b0);
        bus.s_tdata  = 32'h0003_3303;
        bus.s_tlast  = 1'b1;
        bus.s_tvalid = 1'b1;
        wait_cycles(3);
        n_cmp++; if (bus.s_tready !== 1'b0) begin n_err++; $display("FAIL bp_tready: got %b expected 0", bus.s_tready); end
        n_cmp++; if (bus.m_valid !== 2'b10) begin n_err++; $display("FAIL bp_valid: got %b expected 10", bus.m_valid); end
        n_cmp++; if (bus.m_data[15:8] !== 8'h11) begin n_err++; $display("FAIL bp_head: got %h expected 11", bus.m_data[15:8]); end
        bus.m_ready = 2'b11;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_release: tready stayed 0, expected 1"); end
        @(posedge clk);
        #1;
        bus.s_tvalid = 1'b0;
        d0 = drop_count;
        send_beat(32'h0000_00FF, 1'b0);
        n_cmp++; if (drop_count !== d0 + 16'd1) begin n_err++; $display("FAIL bp_drop: got %0d expected %0d", drop_count, d0 + 16'd1); end
        n_cmp++; if (drop_count !== exp_drop) begin n_err++; $display("FAIL bp_drop_model: got %0d expected %0d", drop_count, exp_drop); end
        wait_cycles(4);
    endtask

    task automatic test_packet_fwd();
        int p0, p1;
        set_mode(MODE_PACKET);
        bus.m_ready = 2'b11;
        p0 = n_pop[0];
        p1 = n_pop[1];
        send_beat(32'h0000_0001, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pkt_busy: got %b expected 1", busy); end
        send_beat(32'h0000_0011, 1'b0);
        send_beat(32'h0000_0022, 1'b0);
        send_beat(32'h0000_0033, 1'b1);
        wait_cycles(4);
        n_cmp++; if (n_pop[1] - p1 !== 3) begin n_err++; $display("FAIL pkt_ch1_beats: got %0d expected 3", n_pop[1] - p1); end
        n_cmp++; if (n_pop[0] - p0 !== 0) begin n_err++; $display("FAIL pkt_ch0_beats: got %0d expected 0", n_pop[0] - p0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pkt_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_packet_drop();
        logic [15:0] d0;
        int          p;
        d0 = drop_count;
        p  = n_pop[0] + n_pop[1];
        send_beat(32'h0000_0007, 1'b0);
        for (int i = 0; i < 3; i++) send_beat($urandom(), 1'b0);
        send_beat(32'h0000_0044, 1'b1);
        wait_cycles(3);
        n_cmp++; if (drop_count !== d0 + 16'd5) begin n_err++; $display("FAIL drop_count: got %0d expected %0d", drop_count, d0 + 16'd5); end
        n_cmp++; if (n_pop[0] + n_pop[1] !== p) begin n_err++; $display("FAIL drop_emitted: got %0d beats expected 0", n_pop[0] + n_pop[1] - p); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_packet();
        int p1;
        bus.m_ready = 2'b00;
        send_beat(32'h0000_0000, 1'b0);
        send_beat(32'h0000_0044, 1'b0);
        send_beat(32'h0000_0055, 1'b0);
        n_cmp++; if (bus.m_valid !== 2'b01 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pre: got valid=%b busy=%b expected valid=01 busy=1", bus.m_valid, busy); end
        rst = 1'b1;
        wait_cycles(1);
        n_cmp++; if (bus.m_valid !== 2'b00) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 00", bus.m_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        rst = 1'b0;
        bus.m_ready = 2'b11;
        set_mode(MODE_PACKET);
        p1 = n_pop[1];
        send_beat(32'h0000_0001, 1'b0);
        send_beat(32'h0000_00AB, 1'b1);
        wait_cycles(3);
        n_cmp++; if (n_pop[1] - p1 !== 1) begin n_err++; $display("FAIL mid_reroute: got %0d beats expected 1", n_pop[1] - p1); end
    endtask

    task automatic test_random(input logic mode, input int n_beats);
        int          sent  = 0;
        int          cyc   = 0;
        int          rem   = 0;
        int          len;
        bit          acc;
        logic [31:0] d;
        set_mode(mode);
        while ((sent < n_beats || (mode == MODE_PACKET && (rem != 0 || bus.s_tvalid)))
               && cyc < 20 * n_beats) begin
            bus.m_ready = 2'($urandom_range(0, 3));
            if (!bus.s_tvalid && $urandom_range(0, 3) != 0) begin
                d = $urandom();
                if (mode == MODE_BEAT) begin
                    d[17:16]    = 2'($urandom_range(0, 3));
                    bus.s_tlast = 1'($urandom_range(0, 1));
                end else if (rem == 0) begin
                    d[7:0]      = 8'($urandom_range(0, 3));
                    len         = $urandom_range(0, 4);
                    rem         = len;
                    bus.s_tlast = (len == 0);
                end else begin
                    rem         = rem - 1;
                    bus.s_tlast = (rem == 0);
                end
                bus.s_tdata  = d;
                bus.s_tvalid = 1'b1;
            end
            @(negedge clk);
            acc = bus.s_tvalid && bus.s_tready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                bus.s_tvalid = 1'b0;
                sent++;
            end
        end
        n_cmp++; if (cyc >= 20 * n_beats) begin n_err++; $display("FAIL rand_timeout: sent %0d beats expected %0d", sent, n_beats); end
        bus.s_tvalid = 1'b0;
        bus.m_ready  = 2'b11;
        wait_cycles(10);
        for (int c = 0; c < NCH; c++) begin
            n_cmp++; if (exp_q[c].size() != 0) begin n_err++; $display("FAIL rand_drain_ch%0d: got %0d pending expected 0", c, exp_q[c].size()); end
        end
        n_cmp++; if (drop_count !== exp_drop) begin n_err++; $display("FAIL rand_drop: got %0d expected %0d", drop_count, exp_drop); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_saturate();
        bus2.m_ready  = 2'b11;
        bus2.s_tdata  = 32'h0000_1234;
        bus2.s_tlast  = 1'b0;
        bus2.s_tvalid = 1'b1;
        wait_cycles(14);
        n_cmp++; if (drop_count2 !== 4'd14) begin n_err++; $display("FAIL sat_count14: got %0d expected 14", drop_count2); end
        wait_cycles(1);
        n_cmp++; if (drop_count2 !== 4'd15) begin n_err++; $display("FAIL sat_count15: got %0d expected 15", drop_count2); end
        wait_cycles(5);
        n_cmp++; if (drop_count2 !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d expected 15", drop_count2); end
        n_cmp++; if (bus2.m_valid !== 2'b00) begin n_err++; $display("FAIL sat_no_push: got %b expected 00", bus2.m_valid); end
        bus2.s_tvalid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        cfg_mode      = MODE_BEAT;
        bus.s_tdata   = '0;
        bus.s_tstrb   = '1;
        bus.s_tlast   = 1'b0;
        bus.s_tvalid  = 1'b0;
        bus.m_ready   = 2'b11;
        bus2.s_tdata  = '0;
        bus2.s_tstrb  = '1;
        bus2.s_tlast  = 1'b0;
        bus2.s_tvalid = 1'b0;
        bus2.m_ready  = 2'b11;
        for (int c = 0; c < NCH; c++) n_pop[c] = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_beat_basic();
        test_backpressure();
        test_packet_fwd();
        test_packet_drop();
        test_reset_mid_packet();
        test_random(MODE_BEAT, 3000);
        test_random(MODE_PACKET, 3000);
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
